// File: rtl/debug_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debug_pkg                                                            |
// | Shared state encodings, section codes and helpers for the debug dump.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package debug_pkg;

    localparam int NB_DATA_DEFAULT = 32;

    localparam int NB_STATE = 3;
    typedef logic [NB_STATE-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_LOAD   = 3'd2;
    localparam state_t ST_SEND   = 3'd3;
    localparam state_t ST_NEXT   = 3'd4;
    localparam state_t ST_FINISH = 3'd5;

    typedef logic [1:0] section_t;

    localparam section_t SEC_PC  = 2'd0;
    localparam section_t SEC_REG = 2'd1;
    localparam section_t SEC_MEM = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dump_addr_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dump_addr_counter                                                    |
// | Section/index walker: PC (1 word) -> REG[0..N-1] -> MEM[0..M-1].     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dump_addr_counter
    import debug_pkg::*;
#(
    parameter int N_REGS = 32,
    parameter int N_MEM  = 32,
    parameter int NB_IDX = 5
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_adv,
    output section_t          o_section,
    output logic [NB_IDX-1:0] o_index,
    output logic              o_last_word
);

    localparam logic [NB_IDX-1:0] c_REG_LAST = NB_IDX'(N_REGS - 1);
    localparam logic [NB_IDX-1:0] c_MEM_LAST = NB_IDX'(N_MEM - 1);
    localparam logic [NB_IDX-1:0] c_ONE      = NB_IDX'(1);

    section_t          r_section;
    logic [NB_IDX-1:0] r_index;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_section <= SEC_PC;
            r_index   <= '0;
        end else if (i_clr) begin
            r_section <= SEC_PC;
            r_index   <= '0;
        end else if (i_adv) begin
            case (r_section)
                SEC_PC: begin
                    r_section <= SEC_REG;
                    r_index   <= '0;
                end
                SEC_REG: begin
                    if (r_index == c_REG_LAST) begin
                        r_section <= SEC_MEM;
                        r_index   <= '0;
                    end else begin
                        r_index <= r_index + c_ONE;
                    end
                end
                SEC_MEM: begin
                    // Explicit compare so non-power-of-two depths wrap correctly
                    if (r_index == c_MEM_LAST) begin
                        r_index <= '0;
                    end else begin
                        r_index <= r_index + c_ONE;
                    end
                end
                default: begin
                    r_section <= SEC_PC;
                    r_index   <= '0;
                end
            endcase
        end
    end

    assign o_section   = r_section;
    assign o_index     = r_index;
    assign o_last_word = (r_section == SEC_MEM) && (r_index == c_MEM_LAST);

endmodule
`default_nettype wire

// File: rtl/debug_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | debug_tx_scheduler                                                   |
// | Walks PC, register file and data memory, feeding one word at a time  |
// | to the byte splitter and waiting for its completion pulse.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module debug_tx_scheduler
    import debug_pkg::*;
#(
    parameter int NB_DATA     = NB_DATA_DEFAULT,
    parameter int N_REGS      = 32,
    parameter int N_MEM       = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int NB_MEM_ADDR = 5
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NB_DATA-1:0]     pc_in,
    output logic [NB_REG_ADDR-1:0] reg_addr,
    input  logic [NB_DATA-1:0]     reg_data,
    output logic [NB_MEM_ADDR-1:0] mem_addr,
    input  logic [NB_DATA-1:0]     mem_data,
    output logic [NB_DATA-1:0]     word,
    output logic                   enviar,
    input  logic                   split_done,
    output logic                   busy,
    output logic                   dump_done
);

    localparam int NB_IDX = max_int(NB_REG_ADDR, NB_MEM_ADDR);

    state_t                 r_state;
    state_t                 w_state_d;
    logic [NB_DATA-1:0]     r_pc;
    logic [NB_DATA-1:0]     r_word;
    logic [NB_REG_ADDR-1:0] r_reg_addr;
    logic [NB_MEM_ADDR-1:0] r_mem_addr;
    logic                   r_enviar;
    logic                   r_busy;
    logic                   r_dump_done;
    logic                   r_last;

    section_t               w_section;
    logic [NB_IDX-1:0]      w_index;
    logic                   w_last_word;
    logic                   w_clr;
    logic                   w_adv;

    // Counter advances as SEND completes, so NEXT already sees the new index
    assign w_clr = (r_state == ST_IDLE);
    assign w_adv = (r_state == ST_SEND) && split_done && !abort;

    dump_addr_counter #(
        .N_REGS (N_REGS),
        .N_MEM  (N_MEM),
        .NB_IDX (NB_IDX)
    ) u_addr_counter (
        .clk         (clk),
        .reset       (reset),
        .i_clr       (w_clr),
        .i_adv       (w_adv),
        .o_section   (w_section),
        .o_index     (w_index),
        .o_last_word (w_last_word)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE:   if (start && !abort) w_state_d = ST_FETCH;
            ST_FETCH:  w_state_d = ST_LOAD;
            ST_LOAD:   w_state_d = ST_SEND;
            ST_SEND:   if (split_done) w_state_d = ST_NEXT;
            ST_NEXT:   w_state_d = r_last ? ST_FINISH : ST_FETCH;
            ST_FINISH: w_state_d = ST_IDLE;
            default:   w_state_d = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_word      <= '0;
            r_reg_addr  <= '0;
            r_mem_addr  <= '0;
            r_enviar    <= 1'b0;
            r_busy      <= 1'b0;
            r_dump_done <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_enviar    <= (w_state_d == ST_SEND);
            r_busy      <= (w_state_d != ST_IDLE);
            r_dump_done <= (w_state_d == ST_FINISH);

            if (r_state == ST_IDLE) begin
                r_pc <= pc_in;
            end

            if (w_adv) begin
                r_last <= w_last_word;
            end

            // Address is presented in FETCH so the 1-cycle read lands in LOAD
            if (w_state_d == ST_FETCH) begin
                if (w_section == SEC_REG) begin
                    r_reg_addr <= w_index[NB_REG_ADDR-1:0];
                end
                if (w_section == SEC_MEM) begin
                    r_mem_addr <= w_index[NB_MEM_ADDR-1:0];
                end
            end

            if (r_state == ST_LOAD) begin
                case (w_section)
                    SEC_PC:  r_word <= r_pc;
                    SEC_REG: r_word <= reg_data;
                    default: r_word <= mem_data;
                endcase
            end
        end
    end

    assign reg_addr  = r_reg_addr;
    assign mem_addr  = r_mem_addr;
    assign word      = r_word;
    assign enviar    = r_enviar;
    assign busy      = r_busy;
    assign dump_done = r_dump_done;

endmodule
`default_nettype wire
